player_state_ctrl: RTL and testbench



---
 rtl/road_fighter_pkg.sv | 30 +++
 rtl/player_state_ctrl_if.sv | 26 ++
 rtl/player_state_ctrl_frame_timer.sv | 21 ++
 rtl/player_state_ctrl.sv | 164 ++++++++++++++++
 tb/tb_player_state_ctrl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/road_fighter_pkg.sv
// Shared object-table types and constants for the road fighter game.
// Object records are five 11-bit fields: {img_id, x, y, width, height}.
package road_fighter_pkg;

  localparam int unsigned OBJ_FIELDS = 5;
  localparam int unsigned OBJ_W      = 11;

  localparam int unsigned IMG_ID = 0;
  localparam int unsigned X      = 1;
  localparam int unsigned Y      = 2;
  localparam int unsigned W      = 3;
  localparam int unsigned H      = 4;

  typedef logic [0:OBJ_FIELDS-1][0:OBJ_W-1] obj_rec_t;

  typedef enum logic [1:0] {
    DRIVE   = 2'd0,
    CRASH   = 2'd1,
    RESPAWN = 2'd2
  } drive_state_t;

  localparam logic [OBJ_W-1:0] IMG_CAR    = 11'd0;
  localparam logic [OBJ_W-1:0] IMG_SPIN_A = 11'd1;
  localparam logic [OBJ_W-1:0] IMG_SPIN_B = 11'd2;
  localparam logic [OBJ_W-1:0] IMG_NONE   = 11'h7FF;

  // Timer bit that flips the crash/blink animation every 4 frames.
  localparam int unsigned ANIM_BIT = 2;

endpackage

// File: rtl/player_state_ctrl_if.sv
// Key/collision inputs and object-record outputs of the player controller.
interface player_state_ctrl_if;
  import road_fighter_pkg::*;

  logic       frame_start;
  logic       plus_is_pressed;
  logic       minus_is_pressed;
  logic       left_is_pressed;
  logic       right_is_pressed;
  logic       collision;
  obj_rec_t   new_player_state;
  logic [3:0] scroll_step;
  logic [1:0] drive_state;

  modport master (
    output frame_start, plus_is_pressed, minus_is_pressed,
           left_is_pressed, right_is_pressed, collision,
    input  new_player_state, scroll_step, drive_state
  );

  modport slave (
    input  frame_start, plus_is_pressed, minus_is_pressed,
           left_is_pressed, right_is_pressed, collision,
    output new_player_state, scroll_step, drive_state
  );
endinterface

// File: rtl/player_state_ctrl_frame_timer.sv
// Frame-gated up-counter with synchronous clear and a terminal-count compare.
module frame_timer #(
  parameter int unsigned WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] terminal,
  output logic [WIDTH-1:0] cnt,
  output logic             tc_c
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   cnt <= '0;
    else if (en) cnt <= clr ? '0 : WIDTH'(cnt + 1'b1);
  end

  assign tc_c = (cnt == terminal);

endmodule

// File: rtl/player_state_ctrl.sv
// Per-frame player car controller: speed, steering, crash spin and respawn blink.
// Produces the player object record and the road scroll step.
module player_state_ctrl
  import road_fighter_pkg::*;
#(
  parameter int unsigned X_INIT       = 300,
  parameter int unsigned Y_POS        = 7,
  parameter int unsigned CAR_W        = 16,
  parameter int unsigned CAR_H        = 32,
  parameter int unsigned ROAD_X_MIN   = 106,
  parameter int unsigned ROAD_X_MAX   = 424,
  parameter int unsigned MAX_SPEED    = 15,
  parameter int unsigned ACCEL_FRAMES = 4,
  parameter int unsigned STEER_STEP   = 2,
  parameter int unsigned CRASH_FRAMES = 60,
  parameter int unsigned BLINK_FRAMES = 60
) (
  input  logic                 clk,
  input  logic                 reset,
  player_state_ctrl_if.slave   bus
);

  localparam int unsigned TMR_W = 7;
  localparam int unsigned ACC_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

  localparam logic [TMR_W-1:0]   CRASH_LAST = TMR_W'(CRASH_FRAMES - 1);
  localparam logic [TMR_W-1:0]   BLINK_LAST = TMR_W'(BLINK_FRAMES - 1);
  localparam logic [ACC_W-1:0]   ACC_LAST   = ACC_W'(ACCEL_FRAMES - 1);
  localparam logic [3:0]         SPD_MAX    = 4'(MAX_SPEED);
  localparam logic [OBJ_W-1:0]   X_START    = OBJ_W'(X_INIT);
  localparam logic signed [11:0] X_LO       = 12'(ROAD_X_MIN);
  localparam logic signed [11:0] X_HI       = 12'(ROAD_X_MAX - CAR_W);
  localparam logic signed [11:0] STEP       = 12'(STEER_STEP);

  drive_state_t     state_q;
  logic [3:0]       speed_q;
  logic [OBJ_W-1:0] x_q;
  logic [OBJ_W-1:0] img_q;
  logic             coll_latch_q;

  logic             crash_go_c;
  logic             acc_clr_c, acc_tc_c;
  logic [ACC_W-1:0] acc_cnt;
  logic             tmr_clr_c, tmr_tc_c;
  logic [TMR_W-1:0] tmr_cnt, tmr_terminal_c, tmr_nxt_c;
  logic [3:0]       speed_nxt_c;
  logic [OBJ_W-1:0] x_steer_c;
  logic signed [11:0] x_wide_c, x_left_c, x_right_c;
  obj_rec_t         rec_c;

  frame_timer #(.WIDTH(ACC_W)) u_accel_timer (
    .clk      (clk),
    .reset    (reset),
    .en       (bus.frame_start),
    .clr      (acc_clr_c),
    .terminal (ACC_LAST),
    .cnt      (acc_cnt),
    .tc_c     (acc_tc_c)
  );

  frame_timer #(.WIDTH(TMR_W)) u_anim_timer (
    .clk      (clk),
    .reset    (reset),
    .en       (bus.frame_start),
    .clr      (tmr_clr_c),
    .terminal (tmr_terminal_c),
    .cnt      (tmr_cnt),
    .tc_c     (tmr_tc_c)
  );

  // Frame decision: crash detection, counter control, speed and steering.
  always_comb begin
    crash_go_c     = (state_q == DRIVE) && (coll_latch_q || bus.collision);
    acc_clr_c      = (state_q == CRASH) || crash_go_c || bus.minus_is_pressed ||
                     !bus.plus_is_pressed || acc_tc_c;
    tmr_clr_c      = ((state_q != CRASH) && (state_q != RESPAWN)) || tmr_tc_c;
    tmr_terminal_c = (state_q == CRASH) ? CRASH_LAST : BLINK_LAST;
    tmr_nxt_c      = TMR_W'(tmr_cnt + 1'b1);

    speed_nxt_c = speed_q;
    if ((state_q == CRASH) || crash_go_c)
      speed_nxt_c = '0;
    else if (bus.minus_is_pressed)
      speed_nxt_c = (speed_q < 4'd2) ? 4'd0 : 4'(speed_q - 4'd2);
    else if (bus.plus_is_pressed && acc_tc_c)
      speed_nxt_c = (speed_q >= SPD_MAX) ? SPD_MAX : 4'(speed_q + 4'd1);

    // Signed 12-bit intermediates keep x - STEP from wrapping near zero.
    x_wide_c  = $signed({1'b0, x_q});
    x_left_c  = x_wide_c - STEP;
    x_right_c = x_wide_c + STEP;
    x_steer_c = x_q;
    if (bus.left_is_pressed && !bus.right_is_pressed)
      x_steer_c = (x_left_c < X_LO) ? OBJ_W'(X_LO) : OBJ_W'(x_left_c);
    else if (bus.right_is_pressed && !bus.left_is_pressed)
      x_steer_c = (x_right_c > X_HI) ? OBJ_W'(X_HI) : OBJ_W'(x_right_c);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= DRIVE;
      speed_q      <= '0;
      x_q          <= X_START;
      img_q        <= IMG_CAR;
      coll_latch_q <= 1'b0;
    end else begin
      if (bus.frame_start)
        coll_latch_q <= 1'b0;
      else if (bus.collision && (state_q == DRIVE))
        coll_latch_q <= 1'b1;

      if (bus.frame_start) begin
        speed_q <= speed_nxt_c;
        case (state_q)
          DRIVE: begin
            x_q <= x_steer_c;
            if (crash_go_c) begin
              state_q <= CRASH;
              img_q   <= IMG_SPIN_A;
            end else begin
              img_q   <= IMG_CAR;
            end
          end
          CRASH: begin
            if (tmr_tc_c) begin
              state_q <= RESPAWN;
              x_q     <= X_START;
              img_q   <= IMG_CAR;
            end else begin
              img_q   <= tmr_nxt_c[ANIM_BIT] ? IMG_SPIN_B : IMG_SPIN_A;
            end
          end
          RESPAWN: begin
            x_q <= x_steer_c;
            if (tmr_tc_c) begin
              state_q <= DRIVE;
              img_q   <= IMG_CAR;
            end else begin
              img_q   <= tmr_nxt_c[ANIM_BIT] ? IMG_NONE : IMG_CAR;
            end
          end
          default: begin
            state_q <= DRIVE;
            img_q   <= IMG_CAR;
          end
        endcase
      end
    end
  end

  always_comb begin
    rec_c         = '0;
    rec_c[IMG_ID] = img_q;
    rec_c[X]      = x_q;
    rec_c[Y]      = OBJ_W'(Y_POS);
    rec_c[W]      = OBJ_W'(CAR_W);
    rec_c[H]      = OBJ_W'(CAR_H);
  end

  assign bus.new_player_state = rec_c;
  assign bus.scroll_step      = speed_q;
  assign bus.drive_state      = 2'(state_q);

endmodule

// File: tb/tb_player_state_ctrl.sv
// Randomized and directed bench for player_state_ctrl against a per-frame model.
module tb_player_state_ctrl;
  import road_fighter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  player_state_ctrl_if bus ();

  player_state_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: 0=driving, 1=spinning, 2=blinking
  int m_mode, m_speed, m_x, m_acc, m_age;
  bit m_hit;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_img();
    int phase = (m_age / 4) % 2;
    if (m_mode == 1) return (phase != 0) ? 2 : 1;
    if (m_mode == 2) return (phase != 0) ? 2047 : 0;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_speed = 0; m_x = 300; m_acc = 0; m_age = 0; m_hit = 0;
  endtask

  task automatic model_frame(input bit p, input bit m, input bit l, input bit r, input bit coll);
    bit crash_now = (m_mode == 0) && (m_hit || coll);
    m_hit = 0;
    if (m_mode != 1) begin
      if (l && !r) m_x = (m_x - 2 < 106) ? 106 : m_x - 2;
      else if (r && !l) m_x = (m_x + 2 > 408) ? 408 : m_x + 2;
    end
    if (m_mode == 1 || crash_now) begin
      m_speed = 0; m_acc = 0;
    end else if (m) begin
      m_speed = (m_speed < 2) ? 0 : m_speed - 2; m_acc = 0;
    end else if (p) begin
      if (m_acc == 3) begin
        m_acc = 0;
        if (m_speed < 15) m_speed++;
      end else m_acc++;
    end else m_acc = 0;
    if (m_mode == 0) begin
      if (crash_now) begin m_mode = 1; m_age = 0; end
    end else begin
      m_age++;
      if (m_age == 60) begin
        m_age = 0;
        if (m_mode == 1) begin m_mode = 2; m_x = 300; end
        else m_mode = 0;
      end
    end
  endtask

  task automatic check_outputs(input string ctx);
    check_eq({ctx, ".state"}, 32'(bus.drive_state), 32'(m_mode));
    check_eq({ctx, ".speed"}, 32'(bus.scroll_step), 32'(m_speed));
    check_eq({ctx, ".x"},     32'(bus.new_player_state[X]), 32'(m_x));
    check_eq({ctx, ".img"},   32'(bus.new_player_state[IMG_ID]), 32'(model_img()));
    check_eq({ctx, ".y"},     32'(bus.new_player_state[Y]), 32'd7);
    check_eq({ctx, ".w"},     32'(bus.new_player_state[W]), 32'd16);
    check_eq({ctx, ".h"},     32'(bus.new_player_state[H]), 32'd32);
  endtask

  // One frame: keys valid on the frame_start cycle only, optional mid-frame hit.
  task automatic do_frame(input bit p, input bit m, input bit l, input bit r,
                          input bit coll_fs, input bit coll_mid);
    @(negedge clk);
    bus.plus_is_pressed  = p;
    bus.minus_is_pressed = m;
    bus.left_is_pressed  = l;
    bus.right_is_pressed = r;
    bus.frame_start      = 1'b1;
    bus.collision        = coll_fs;
    @(negedge clk);
    bus.frame_start      = 1'b0;
    bus.collision        = 1'b0;
    {bus.plus_is_pressed, bus.minus_is_pressed,
     bus.left_is_pressed, bus.right_is_pressed} = 4'($urandom);
    model_frame(p, m, l, r, coll_fs);
    check_outputs("frame");
    if (coll_mid) begin
      bus.collision = 1'b1;
      @(negedge clk);
      bus.collision = 1'b0;
      if (m_mode == 0) m_hit = 1;
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1 check_outputs("async_rst");
    @(negedge clk);
    check_outputs("rst");
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.frame_start = 0; bus.collision = 0;
    bus.plus_is_pressed = 0; bus.minus_is_pressed = 0;
    bus.left_is_pressed = 0; bus.right_is_pressed = 0;
    model_reset();
    #1 check_outputs("init");
    apply_reset();

    repeat (8) do_frame(1, 0, 0, 0, 0, 0);
    check_eq("plus8_speed", 32'(bus.scroll_step), 32'd2);
    repeat (60) do_frame(1, 0, 0, 0, 0, 0);
    check_eq("plus_sat", 32'(bus.scroll_step), 32'd15);

    repeat (8) do_frame(0, 1, 0, 0, 0, 0);
    repeat (20) do_frame(1, 0, 0, 0, 0, 0);
    check_eq("speed5", 32'(bus.scroll_step), 32'd5);
    repeat (2) do_frame(1, 1, 0, 0, 0, 0);
    check_eq("brake_pri", 32'(bus.scroll_step), 32'd1);
    do_frame(1, 1, 0, 0, 0, 0);
    check_eq("brake_floor", 32'(bus.scroll_step), 32'd0);

    repeat (96) do_frame(0, 0, 1, 0, 0, 0);
    check_eq("x108", 32'(bus.new_player_state[X]), 32'd108);
    repeat (3) do_frame(0, 0, 1, 0, 0, 0);
    check_eq("x_left_clamp", 32'(bus.new_player_state[X]), 32'd106);
    repeat (150) do_frame(0, 0, 0, 1, 0, 0);
    repeat (2) do_frame(0, 0, 0, 1, 0, 0);
    check_eq("x_right_clamp", 32'(bus.new_player_state[X]), 32'd408);
    do_frame(0, 0, 1, 1, 0, 0);

    repeat (12) do_frame(1, 0, 0, 0, 0, 0);
    do_frame(1, 0, 0, 0, 0, 1);
    do_frame(1, 0, 0, 0, 0, 0);
    check_eq("crash_enter", 32'(bus.drive_state), 32'd1);
    check_eq("crash_speed", 32'(bus.scroll_step), 32'd0);
    repeat (59) do_frame(1, 0, 1, 0, 0, 0);
    do_frame(0, 0, 0, 0, 0, 0);
    check_eq("respawn_enter", 32'(bus.drive_state), 32'd2);
    check_eq("respawn_x", 32'(bus.new_player_state[X]), 32'd300);
    repeat (59) do_frame(0, 0, 0, 0, 1, 1);
    check_eq("respawn_ignores_hit", 32'(bus.drive_state), 32'd2);
    do_frame(0, 0, 0, 0, 0, 0);
    check_eq("drive_back", 32'(bus.drive_state), 32'd0);
    check_eq("drive_img", 32'(bus.new_player_state[IMG_ID]), 32'd0);

    do_frame(0, 0, 0, 0, 1, 0);
    repeat (30) do_frame(0, 0, 0, 0, 0, 0);
    apply_reset();
    repeat (4) do_frame(1, 0, 0, 0, 0, 0);
    check_eq("post_rst_speed", 32'(bus.scroll_step), 32'd1);

    for (int i = 0; i < 700; i++) begin
      logic [31:0] rnd = $urandom;
      if (rnd[31:24] == 8'd0) apply_reset();
      do_frame(rnd[0] | rnd[1], rnd[2] & rnd[3], rnd[4], rnd[5],
               rnd[12:8] == 5'd0, rnd[20:16] == 5'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
